// File: rtl/cbus_sram_responder.sv
// cbus responder backed by a word-addressed 64-bit array with byte-strobed writes.
// One transaction in flight; beats follow a programmable first-beat latency.

package cbus_pkg;
    typedef enum logic [1:0] {
        BURST_FIXED = 2'd0,
        BURST_INCR  = 2'd1
    } cbus_burst_e;

    typedef struct packed {
        logic        valid;
        logic        is_write;
        logic [2:0]  size;
        logic [31:0] addr;
        logic [63:0] data;
        logic [7:0]  strobe;
        logic [3:0]  len;
        logic [1:0]  burst;
    } cbus_req_t;

    typedef struct packed {
        logic        ready;
        logic [63:0] data;
        logic        last;
    } cbus_resp_t;
endpackage

module cbus_sram_responder
    import cbus_pkg::*;
#(
    parameter int DEPTH_WORDS = 4096,
    parameter int LATENCY     = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  cbus_req_t  creq,
    output cbus_resp_t cresp,
    output logic       busy
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam logic [3:0] LAT_INIT = 4'((LATENCY == 0) ? 0 : LATENCY - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_BEAT
    } state_e;

    state_e        state_q;
    logic          is_write_q;
    logic [1:0]    burst_q;
    logic [3:0]    len_q;
    logic [3:0]    lat_q;
    logic [3:0]    beat_q;
    logic [3:0]    beat_d;
    logic [AW-1:0] base_q;
    logic [AW-1:0] idx;
    logic          ready_q;
    logic          last_q;
    logic          wr_en;

    logic [63:0]   mem [DEPTH_WORDS];

    // Transfer size and the address bits outside the array never influence the response.
    logic          unused_req;
    assign unused_req = ^{creq.size, creq.addr};

    assign beat_d = beat_q + 4'd1;
    assign idx    = (burst_q == 2'(BURST_INCR)) ? base_q + AW'(beat_q) : base_q;
    assign wr_en  = (state_q == ST_BEAT) && is_write_q && creq.valid;
    assign busy   = (state_q != ST_IDLE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            is_write_q <= 1'b0;
            burst_q    <= '0;
            len_q      <= '0;
            lat_q      <= '0;
            beat_q     <= '0;
            base_q     <= '0;
            ready_q    <= 1'b0;
            last_q     <= 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (creq.valid) begin
                        is_write_q <= creq.is_write;
                        burst_q    <= creq.burst;
                        len_q      <= creq.len;
                        base_q     <= creq.addr[3 +: AW];
                        beat_q     <= '0;
                        if (LATENCY == 0) begin
                            state_q <= ST_BEAT;
                            ready_q <= 1'b1;
                            last_q  <= (creq.len == 4'd0);
                        end else begin
                            state_q <= ST_WAIT;
                            lat_q   <= LAT_INIT;
                        end
                    end
                end
                ST_WAIT: begin
                    // A dropped valid before the first beat abandons the request silently.
                    if (!creq.valid) begin
                        state_q <= ST_IDLE;
                        lat_q   <= '0;
                    end else if (lat_q == 4'd0) begin
                        state_q <= ST_BEAT;
                        ready_q <= 1'b1;
                        last_q  <= (len_q == 4'd0);
                    end else begin
                        lat_q <= lat_q - 4'd1;
                    end
                end
                ST_BEAT: begin
                    if (!creq.valid || beat_q == len_q) begin
                        state_q <= ST_IDLE;
                        beat_q  <= '0;
                        ready_q <= 1'b0;
                        last_q  <= 1'b0;
                    end else begin
                        beat_q <= beat_d;
                        last_q <= (beat_d == len_q);
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    ready_q <= 1'b0;
                    last_q  <= 1'b0;
                end
            endcase
        end
    end

    // NOTE: the array is deliberately left out of reset so it maps onto plain RAM;
    // stopping writes on reset comes from state_q leaving ST_BEAT, not from this block.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < 8; i++) begin
                if (creq.strobe[i]) begin
                    mem[idx][8*i +: 8] <= creq.data[8*i +: 8];
                end
            end
        end
    end

    always_comb begin
        cresp       = '0;
        cresp.ready = ready_q;
        cresp.last  = last_q;
        cresp.data  = (ready_q && !is_write_q) ? mem[idx] : 64'd0;
    end

endmodule

// File: doc/cbus_sram_responder.md
Name: cbus_sram_responder

Overview:
- Responder (slave) end of the cbus request/response interface that the core drives as initiator on its instruction and data ports.
- Accepts cbus_req_t requests: single or burst, read or write. Services them from an internal word-addressed memory array with programmable first-beat latency.
- Returns one cbus_resp_t beat per cycle: ready, data, last.
- Used as the memory model behind icreq/dcreq in standalone simulation, and as an on-chip scratch RAM.

Parameters:
- DEPTH_WORDS, 4096: number of 64-bit words in the array; must be a power of two.
- LATENCY, 2: idle cycles between request acceptance and the first beat; legal range 0..15.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- creq  input  cbus_req_t  request fields:
  - valid (1)
  - is_write (1)
  - size (3)
  - addr (32)
  - data (64)
  - strobe (8)
  - len (4, encodes beats−1)
  - burst (2; FIXED=0, INCR=1)
- cresp  output  cbus_resp_t  response fields:
  - ready (1)
  - data (64)
  - last (1)
- busy  output  1  high whenever the state is not IDLE.

Behaviour:
- Reset (reset=0, asynchronous):
  - State goes to IDLE; all counters clear.
  - cresp.ready=0, cresp.last=0, cresp.data=0, busy=0.
  - Array contents are not reset.
  - Reset mid-transaction aborts it at once. Beats already acknowledged stay written; no further writes occur.
- States: IDLE, WAIT, BEAT.
- IDLE:
  - When creq.valid=1 at a clock edge, latch is_write, burst, len, and base index = addr[3+log2(DEPTH_WORDS)−1:3]. Clear beat count.
  - Next state is WAIT with latency counter=LATENCY−1 if LATENCY>0; otherwise BEAT.
  - Upper address bits are ignored, so addresses alias modulo the array size.
- WAIT:
  - Counter decrements each cycle; at 0 the next state is BEAT.
  - The first ready therefore appears LATENCY+1 cycles after valid is first sampled.
- BEAT:
  - cresp.ready=1 every cycle, giving one beat per cycle.
  - Beat word index:
    - INCR: (base+beat) mod DEPTH_WORDS, so bursts wrap from word DEPTH_WORDS−1 to word 0.
    - FIXED: base on every beat.
  - Read: cresp.data = array[index], combinational from registered index, valid only while ready=1.
  - Write: at the edge ending the ready cycle, each byte lane i with strobe[i]=1 takes creq.data[8i+7:8i]; other lanes are unchanged. cresp.data=0 during writes.
  - cresp.last=1 exactly when ready=1 and beat==len.
  - After the last beat the next state is IDLE; otherwise beat increments.
  - The initiator drops valid at the edge after last. A new request may be accepted from IDLE the following cycle.
- size does not affect the responder: reads return the full 64-bit word; writes use strobe only.
- Outside BEAT: ready=0, last=0, data=0.
- Protocol violation (creq.valid falls while in WAIT or BEAT before last): abort to IDLE on the next edge. Nothing further is written; no ready is issued.
- Same-cycle read-after-write is impossible: only one transaction is in flight at a time.
- busy = (state != IDLE).

Test Plan:
- Single write, then single read, LATENCY=2:
  - Stimulus: write addr 0x00000008, data 0x1122334455667788, strobe 0xFF, len 0.
  - Required: ready and last high together for exactly one cycle, 3 cycles after valid.
  - Then read addr 0x08 returns 0x1122334455667788 with last=1.
- Byte strobe:
  - Stimulus: write 0xAAAAAAAAAAAAAAAA to addr 0x08 with strobe 0x0F.
  - Required: read of 0x08 returns 0x11223344AAAAAAAA.
- INCR burst:
  - Stimulus: 4-beat INCR write at addr 0x0 (len=3) with data 0,1,2,3; then a 4-beat INCR read.
  - Required: ready high 4 consecutive cycles; data 0,1,2,3 in order; last only on beat 4.
- Wrap and FIXED:
  - Stimulus: 2-beat INCR write at word DEPTH_WORDS−1 with data 5,6.
  - Required: word DEPTH_WORDS−1=5 and word 0=6.
  - Stimulus: 3-beat FIXED write at 0x10 with data 7,8,9.
  - Required: word 2=9.
- Async reset mid-burst:
  - Stimulus: assert reset low during beat 2 of a 4-beat write of A,B,C,D to 0x20; preload that region with 0 first.
  - Required: ready, last and busy drop immediately with no clock edge. Words 4,5 hold A,B; words 6,7 stay 0.
- Early valid drop:
  - Stimulus: deassert valid during WAIT.
  - Required: no ready is ever issued; busy=0 next cycle; memory unchanged.
  - Then LATENCY=0 build: ready appears 1 cycle after valid.
